// File: rtl/ysyx_23060072_lsu_stage_hs_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060072_lsu_stage_hs_pkg
//   Shared definitions for the handshaked LSU stage:
//     - lsu_size_e  : access-size codes carried on lsu_type_i
//     - lsu_state_e : request/response FSM state encoding
//   Optional build macro used by the top level: LSU_PERF_CNT_EN
//   (adds load/store/stall performance counters).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

package ysyx_23060072_lsu_stage_hs_pkg;

  // Access size as encoded on lsu_type_i.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } lsu_size_e;

  // Bus transaction FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/ysyx_23060072_lsu_align.sv
// ----------------------------------------------------------------------------
// ysyx_23060072_lsu_align
//   Purely combinational byte-lane helper for the LSU stage.
//   Store side : shifts store data into its byte lane and builds the strobes.
//   Load side  : extracts the addressed lane from the bus word and zero- or
//                sign-extends it to XLEN.
//   Ports:
//     st_size_i, st_off_i, st_data_i -> st_wdata_o, st_wstrb_o
//     ld_size_i, ld_off_i, ld_signed_i, ld_rdata_i -> ld_data_o
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ysyx_23060072_lsu_align
  import ysyx_23060072_lsu_stage_hs_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8,
  parameter int OFF_W  = $clog2(STRB_W)
) (
  input  logic [1:0]        st_size_i,
  input  logic [OFF_W-1:0]  st_off_i,
  input  logic [XLEN-1:0]   st_data_i,
  output logic [XLEN-1:0]   st_wdata_o,
  output logic [STRB_W-1:0] st_wstrb_o,
  input  logic [1:0]        ld_size_i,
  input  logic [OFF_W-1:0]  ld_off_i,
  input  logic              ld_signed_i,
  input  logic [XLEN-1:0]   ld_rdata_i,
  output logic [XLEN-1:0]   ld_data_o
);

  // Strobe pattern for an access of the given size starting at byte lane off.
  function automatic logic [STRB_W-1:0] st_strobe(input logic [1:0] sz,
                                                   input logic [OFF_W-1:0] off);
    logic [STRB_W-1:0] base;
    case (lsu_size_e'(sz))
      SZ_B:    base = STRB_W'(1);
      SZ_H:    base = STRB_W'(3);
      SZ_W:    base = STRB_W'(15);
      default: base = '1;
    endcase
    return base << off;
  endfunction

  // Keep the low lane bytes and fill the upper bits with zeros or the lane's
  // sign bit. A full-width access passes through untouched.
  function automatic logic [XLEN-1:0] ld_extend(input logic [XLEN-1:0] v,
                                                 input logic [1:0] sz,
                                                 input logic sgn);
    logic [XLEN-1:0] mask;
    logic            sbit;
    case (lsu_size_e'(sz))
      SZ_B: begin
        mask = XLEN'(8'hFF);
        sbit = v[7];
      end
      SZ_H: begin
        mask = XLEN'(16'hFFFF);
        sbit = v[15];
      end
      SZ_W: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sbit = v[31];
      end
      default: begin
        mask = '1;
        sbit = 1'b0;
      end
    endcase
    return (v & mask) | ((sgn && sbit) ? ~mask : '0);
  endfunction

  logic [XLEN-1:0] ld_lane;

  always_comb begin
    st_wdata_o = st_data_i << {st_off_i, 3'b000};
    st_wstrb_o = st_strobe(st_size_i, st_off_i);
    ld_lane    = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_data_o  = ld_extend(ld_lane, ld_size_i, ld_signed_i);
  end

endmodule

// File: rtl/ysyx_23060072_lsu_stage_hs.sv
// ----------------------------------------------------------------------------
// ysyx_23060072_lsu_stage_hs
//   LSU pipeline stage between ex_stage and wb_stage. Forms the effective
//   address, runs one memory transaction at a time over a valid/ready
//   request bus with an always-accepted response channel, aligns load data,
//   and registers the writeback bundle behind a valid/ready output register.
//
//   Ports:
//     clk, rst_n (synchronous, active-low)
//     in_valid_i / in_ready_o           ex_stage bundle handshake
//     wb_flag_i, lsu_type_i, store_flag_i, load_flag_i, lsu_signed_i,
//     wb_addr_i, wb_data_i, operand_a_i, operand_b_i, operand_imm_i
//     mem_req_*                         request channel (valid/ready)
//     mem_resp_*                        response channel (valid only)
//     out_valid_o / out_ready_i         wb_stage bundle handshake
//     wb_flag_o, wb_addr_o, wb_data_lsu_o, load_flag_o,
//     exc_misalign_o, exc_bus_err_o     registered writeback bundle
//     lsu_hold_flag_o                   stall indication, = !in_ready_o
//
//   Build option LSU_PERF_CNT_EN adds perf_load_cnt_o, perf_store_cnt_o and
//   perf_stall_cnt_o (32-bit, wrapping).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ysyx_23060072_lsu_stage_hs
  import ysyx_23060072_lsu_stage_hs_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              wb_flag_i,
  input  logic [1:0]        lsu_type_i,
  input  logic              store_flag_i,
  input  logic              load_flag_i,
  input  logic              lsu_signed_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic [XLEN-1:0]   operand_a_i,
  input  logic [XLEN-1:0]   operand_b_i,
  input  logic [XLEN-1:0]   operand_imm_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_req_addr_o,
  output logic              mem_req_wen_o,
  output logic [XLEN-1:0]   mem_req_wdata_o,
  output logic [STRB_W-1:0] mem_req_wstrb_o,
  input  logic              mem_resp_valid_i,
  input  logic [XLEN-1:0]   mem_resp_rdata_i,
  input  logic              mem_resp_err_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              wb_flag_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [XLEN-1:0]   wb_data_lsu_o,
  output logic              load_flag_o,
  output logic              lsu_hold_flag_o,
  output logic              exc_misalign_o,
  output logic              exc_bus_err_o
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_load_cnt_o,
  output logic [31:0]       perf_store_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  localparam int OFF_W = $clog2(STRB_W);

  // Size/offset misalignment. A double access on a 32-bit datapath can never
  // be serviced, so it is reported as misaligned regardless of address.
  function automatic logic misaligned(input logic [1:0] sz,
                                      input logic [OFF_W-1:0] off);
    logic mis;
    case (lsu_size_e'(sz))
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = (XLEN == 32) ? 1'b1 : (|off);
    endcase
    return mis;
  endfunction

  lsu_state_e state_q, state_d;

  logic [XLEN-1:0]   ea;
  logic [OFF_W-1:0]  ea_off;
  logic              is_mem;
  logic              is_mis;
  logic              accept;
  logic              start_mem;
  logic              load_direct;
  logic              load_resp;
  logic [XLEN-1:0]   st_wdata;
  logic [STRB_W-1:0] st_wstrb;
  logic [XLEN-1:0]   ld_data;

  // Transaction held across REQ/WAIT.
  logic [XLEN-1:0]   addr_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic              sgn_q;
  logic              wen_q;
  logic              ld_q;
  logic              wbf_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  always_comb begin
    ea          = operand_a_i + operand_imm_i;
    ea_off      = ea[OFF_W-1:0];
    is_mem      = load_flag_i | store_flag_i;
    is_mis      = misaligned(lsu_type_i, ea_off);
    in_ready_o  = (state_q == ST_IDLE) && (!out_valid_o || out_ready_i);
    accept      = in_valid_i && in_ready_o;
    start_mem   = accept && is_mem && !is_mis;
    // Non-memory and misaligned bundles bypass the bus entirely.
    load_direct = accept && (!is_mem || is_mis);
    // The response channel is only meaningful in WAIT; anything else is stray.
    load_resp   = (state_q == ST_WAIT) && mem_resp_valid_i;
    lsu_hold_flag_o = !in_ready_o;
  end

  ysyx_23060072_lsu_align #(
    .XLEN   (XLEN),
    .STRB_W (STRB_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .st_size_i   (lsu_type_i),
    .st_off_i    (ea_off),
    .st_data_i   (operand_b_i),
    .st_wdata_o  (st_wdata),
    .st_wstrb_o  (st_wstrb),
    .ld_size_i   (size_q),
    .ld_off_i    (off_q),
    .ld_signed_i (sgn_q),
    .ld_rdata_i  (mem_resp_rdata_i),
    .ld_data_o   (ld_data)
  );

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_mem)        state_d = ST_REQ;
      ST_REQ:  if (mem_req_ready_i)  state_d = ST_WAIT;
      ST_WAIT: if (mem_resp_valid_i) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // ---- Request capture: fields frozen until the transaction completes ----
  always_ff @(posedge clk) begin
    if (start_mem) begin
      addr_q  <= {ea[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      size_q  <= lsu_type_i;
      off_q   <= ea_off;
      sgn_q   <= lsu_signed_i;
      wen_q   <= store_flag_i;
      ld_q    <= load_flag_i && !store_flag_i;
      wbf_q   <= wb_flag_i;
      rd_q    <= wb_addr_i;
      wdata_q <= st_wdata;
      wstrb_q <= store_flag_i ? st_wstrb : '0;
    end
  end

  always_comb begin
    mem_req_valid_o = (state_q == ST_REQ);
    mem_req_addr_o  = addr_q;
    mem_req_wen_o   = wen_q;
    mem_req_wdata_o = wdata_q;
    mem_req_wstrb_o = wstrb_q;
  end

  // ---- Writeback output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_o    <= 1'b0;
      wb_flag_o      <= 1'b0;
      wb_addr_o      <= '0;
      wb_data_lsu_o  <= '0;
      load_flag_o    <= 1'b0;
      exc_misalign_o <= 1'b0;
      exc_bus_err_o  <= 1'b0;
    end else if (load_direct) begin
      out_valid_o    <= 1'b1;
      wb_flag_o      <= is_mem ? 1'b0 : wb_flag_i;
      wb_addr_o      <= wb_addr_i;
      wb_data_lsu_o  <= is_mem ? '0 : wb_data_i;
      load_flag_o    <= load_flag_i && !store_flag_i;
      exc_misalign_o <= is_mem;
      exc_bus_err_o  <= 1'b0;
    end else if (load_resp) begin
      out_valid_o    <= 1'b1;
      wb_flag_o      <= wbf_q && ld_q && !mem_resp_err_i;
      wb_addr_o      <= rd_q;
      wb_data_lsu_o  <= ld_q ? ld_data : '0;
      load_flag_o    <= ld_q;
      exc_misalign_o <= 1'b0;
      exc_bus_err_o  <= mem_resp_err_i;
    end else if (out_ready_i) begin
      out_valid_o    <= 1'b0;
    end
  end

`ifdef LSU_PERF_CNT_EN
  // ---- Performance counters ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_load_cnt_o  <= '0;
      perf_store_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (load_resp && ld_q)   perf_load_cnt_o  <= perf_load_cnt_o + 32'd1;
      if (load_resp && wen_q)  perf_store_cnt_o <= perf_store_cnt_o + 32'd1;
      if (lsu_hold_flag_o)     perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060072_lsu_stage_hs.sv
`timescale 1ns/1ps

module tb_ysyx_23060072_lsu_stage_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        wb_flag_i;
  logic [1:0]  lsu_type_i;
  logic        store_flag_i;
  logic        load_flag_i;
  logic        lsu_signed_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic [31:0] operand_imm_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_wen_o;
  logic [31:0] mem_req_wdata_o;
  logic [3:0]  mem_req_wstrb_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_rdata_i;
  logic        mem_resp_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        wb_flag_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_lsu_o;
  logic        load_flag_o;
  logic        lsu_hold_flag_o;
  logic        exc_misalign_o;
  logic        exc_bus_err_o;

  always #5 clk = ~clk;

  ysyx_23060072_lsu_stage_hs #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .wb_flag_i(wb_flag_i), .lsu_type_i(lsu_type_i),
    .store_flag_i(store_flag_i), .load_flag_i(load_flag_i),
    .lsu_signed_i(lsu_signed_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operand_imm_i(operand_imm_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
    .mem_resp_err_i(mem_resp_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .wb_flag_o(wb_flag_o), .wb_addr_o(wb_addr_o), .wb_data_lsu_o(wb_data_lsu_o),
    .load_flag_o(load_flag_o), .lsu_hold_flag_o(lsu_hold_flag_o),
    .exc_misalign_o(exc_misalign_o), .exc_bus_err_o(exc_bus_err_o)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        flag;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        care;
    logic        ld;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t        out_q[$];
  logic        m_busy = 1'b0;   // memory transaction outstanding
  logic        m_req  = 1'b0;   // request not yet handshaked
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wen;
  int          p_off, p_nb;
  logic        p_sgn, p_ld, p_flag;
  logic [4:0]  p_rd;

  function automatic logic [31:0] extract(input logic [31:0] w, input int off,
                                          input int nb, input logic sgn);
    logic [63:0] v;
    v = ({32'd0, w} >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
    if (sgn && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  initial begin : monitor
    exp_t        e;
    logic        exp_rdy;
    logic [31:0] ea;
    int          off, nb;
    logic        mis, mem;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_q.delete();
        m_busy = 1'b0;
        m_req  = 1'b0;
      end else begin
        exp_rdy = !m_busy && (out_q.size() == 0 || out_ready_i);
        chk("out_valid", {31'd0, out_valid_o}, {31'd0, out_q.size() != 0});
        chk("in_ready", {31'd0, in_ready_o}, {31'd0, exp_rdy});
        chk("hold", {31'd0, lsu_hold_flag_o}, {31'd0, !exp_rdy});
        chk("req_valid", {31'd0, mem_req_valid_o}, {31'd0, m_req});
        if (out_valid_o && out_q.size() != 0) begin
          e = out_q[0];
          chk("out_flag", {31'd0, wb_flag_o}, {31'd0, e.flag});
          chk("out_rd", {27'd0, wb_addr_o}, {27'd0, e.rd});
          chk("out_ld", {31'd0, load_flag_o}, {31'd0, e.ld});
          chk("out_mis", {31'd0, exc_misalign_o}, {31'd0, e.mis});
          chk("out_err", {31'd0, exc_bus_err_o}, {31'd0, e.err});
          if (e.care) chk("out_data", wb_data_lsu_o, e.data);
        end
        if (mem_req_valid_o && m_req) begin
          chk("req_addr", mem_req_addr_o, r_addr);
          chk("req_wen", {31'd0, mem_req_wen_o}, {31'd0, r_wen});
          chk("req_wstrb", {28'd0, mem_req_wstrb_o}, {28'd0, r_wstrb});
          if (r_wen) chk("req_wdata", mem_req_wdata_o, r_wdata);
        end
        // events at the coming edge
        if (out_valid_o && out_ready_i && out_q.size() != 0) void'(out_q.pop_front());
        if (m_busy) begin
          if (m_req) begin
            if (mem_req_ready_i) m_req = 1'b0;
          end else if (mem_resp_valid_i) begin
            e.rd   = p_rd;
            e.ld   = p_ld;
            e.mis  = 1'b0;
            e.err  = mem_resp_err_i;
            e.flag = p_ld && p_flag && !mem_resp_err_i;
            e.care = p_ld && !mem_resp_err_i;
            e.data = extract(mem_resp_rdata_i, p_off, p_nb, p_sgn);
            out_q.push_back(e);
            m_busy = 1'b0;
          end
        end
        if (in_valid_i && exp_rdy) begin
          ea  = operand_a_i + operand_imm_i;
          off = int'(ea % 4);
          nb  = 1 << lsu_type_i;
          mis = (lsu_type_i == 2'b11) || ((ea % nb) != 0);
          mem = load_flag_i || store_flag_i;
          e.rd   = wb_addr_i;
          e.ld   = load_flag_i;
          e.err  = 1'b0;
          if (!mem || mis) begin
            e.flag = mem ? 1'b0 : wb_flag_i;
            e.data = wb_data_i;
            e.care = !mem;
            e.mis  = mem;
            out_q.push_back(e);
          end else begin
            m_busy = 1'b1;
            m_req  = 1'b1;
            r_addr = ea - off;
            r_wen  = store_flag_i;
            r_wstrb = store_flag_i ? 4'(((1 << nb) - 1) << off) : 4'd0;
            r_wdata = operand_b_i << (8 * off);
            p_off = off; p_nb = nb; p_sgn = lsu_signed_i;
            p_ld = load_flag_i; p_flag = wb_flag_i; p_rd = wb_addr_i;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] a, input logic [31:0] imm,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] d);
    load_flag_i = ld; store_flag_i = st; lsu_type_i = sz; lsu_signed_i = sgn;
    operand_a_i = a; operand_imm_i = imm; operand_b_i = b;
    wb_addr_i = rd; wb_data_i = d; wb_flag_i = !st;
  endtask

  // Present the current bundle until accepted; returns #1 after the accept edge.
  task automatic send();
    int n;
    in_valid_i = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready_o) break;
      n++;
      if (n > 50) begin
        $display("FAIL send_timeout: in_ready_o stuck at 0");
        n_fail++;
        break;
      end
    end
    step();
    in_valid_i = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    mem_resp_rdata_i = 32'h0; mem_resp_err_i = 1'b0;
    set_op(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr_o}, 32'd0);
    chk("rst_wb_data", wb_data_lsu_o, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

    // ALU pass-through
    set_op(0, 0, 2'b10, 0, 0, 0, 0, 5'd5, 32'h1234);
    send();
    chk("alu_valid", {31'd0, out_valid_o}, 32'd1);
    chk("alu_data", wb_data_lsu_o, 32'h1234);
    chk("alu_rd", {27'd0, wb_addr_o}, 32'd5);

    // lb / lbu at EA 0x103
    for (int s = 1; s >= 0; s--) begin
      set_op(1, 0, 2'b00, s[0], 32'h100, 32'h3, 0, 5'd9, 32'h0);
      send();
      chk("lb_req_valid", {31'd0, mem_req_valid_o}, 32'd1);
      chk("lb_req_addr", mem_req_addr_o, 32'h100);
      chk("lb_req_wstrb", {28'd0, mem_req_wstrb_o}, 32'd0);
      mem_req_ready_i = 1'b1;
      step();
      mem_req_ready_i = 1'b0;
      mem_resp_valid_i = 1'b1; mem_resp_rdata_i = 32'h8012_3456;
      step();
      mem_resp_valid_i = 1'b0;
      chk("lb_out_valid", {31'd0, out_valid_o}, 32'd1);
      chk(s ? "lb_data" : "lbu_data", wb_data_lsu_o, s ? 32'hFFFF_FF80 : 32'h0000_0080);
      step();
    end

    // sh at EA 0x202
    set_op(0, 1, 2'b01, 0, 32'h200, 32'h2, 32'hABCD, 5'd3, 0);
    send();
    chk("sh_wstrb", {28'd0, mem_req_wstrb_o}, 32'hC);
    chk("sh_wdata", mem_req_wdata_o, 32'hABCD_0000);
    chk("sh_wen", {31'd0, mem_req_wen_o}, 32'd1);
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1;
    step();
    mem_resp_valid_i = 1'b0;
    chk("sh_out_valid", {31'd0, out_valid_o}, 32'd1);
    chk("sh_wb_flag", {31'd0, wb_flag_o}, 32'd0);
    step();

    // misaligned lw at EA 0x101
    set_op(1, 0, 2'b10, 0, 32'h100, 32'h1, 0, 5'd4, 0);
    send();
    chk("mis_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
    chk("mis_out_valid", {31'd0, out_valid_o}, 32'd1);
    chk("mis_exc", {31'd0, exc_misalign_o}, 32'd1);
    chk("mis_wb_flag", {31'd0, wb_flag_o}, 32'd0);
    step();

    // stalled request then bus error
    set_op(1, 0, 2'b10, 1, 32'h300, 32'h4, 0, 5'd6, 0);
    send();
    for (int i = 0; i < 4; i++) begin
      chk("stall_req_valid", {31'd0, mem_req_valid_o}, 32'd1);
      chk("stall_req_addr", mem_req_addr_o, 32'h304);
      chk("stall_hold", {31'd0, lsu_hold_flag_o}, 32'd1);
      step();
    end
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_err_i = 1'b1;
    step();
    mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0;
    chk("err_exc", {31'd0, exc_bus_err_o}, 32'd1);
    chk("err_wb_flag", {31'd0, wb_flag_o}, 32'd0);
    step();

    // output backpressure
    out_ready_i = 1'b0;
    set_op(0, 0, 2'b10, 0, 0, 0, 0, 5'd7, 32'h55);
    send();
    set_op(0, 0, 2'b10, 0, 0, 0, 0, 5'd8, 32'h66);
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("bp_data", wb_data_lsu_o, 32'h55);
      step();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    step();

    // reset during WAIT, then a stray response
    set_op(1, 0, 2'b10, 0, 32'h400, 32'h0, 0, 5'd10, 0);
    send();
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstw_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rstw_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
    mem_resp_valid_i = 1'b1; mem_resp_rdata_i = 32'hDEAD_BEEF;
    step();
    mem_resp_valid_i = 1'b0;
    chk("stray_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("stray_in_ready", {31'd0, in_ready_o}, 32'd1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      set_op(kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
             32'($urandom_range(0, 7)), $urandom, 5'($urandom), $urandom);
      wb_flag_i        = 1'($urandom);
      in_valid_i       = ($urandom_range(0, 2) != 0);
      out_ready_i      = ($urandom_range(0, 3) != 0);
      mem_req_ready_i  = 1'($urandom);
      mem_resp_rdata_i = $urandom;
      mem_resp_err_i   = ($urandom_range(0, 5) == 0);
      if (m_busy && !m_req) mem_resp_valid_i = ($urandom_range(0, 2) == 0);
      else                  mem_resp_valid_i = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    in_valid_i = 1'b0; mem_resp_valid_i = 1'b0; rst_n = 1'b1;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
